pll_reset_sequencer: RTL and testbench

//  Supervises one altera_pll instance on the reference-clock side. Pulses the PLL

---
 rtl/pll_seq_pkg.sv | 29 ++
 rtl/bit_sync_2ff.sv | 22 ++
 rtl/pll_reset_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer and its consumers.
package pll_seq_pkg;

  localparam int MAX_PLL_OUTCLKS = 5;

  typedef enum logic [2:0] {
    S_PLLRST   = 3'd0,
    S_WAITLOCK = 3'd1,
    S_FILTER   = 3'd2,
    S_RELEASE  = 3'd3,
    S_RUN      = 3'd4,
    S_FAULT    = 3'd5
  } seq_state_t;

  // One counter serves every timed phase, so it is sized for the longest of them.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    m = (b > m) ? b : m;
    m = (c > m) ? c : m;
    m = (d > m) ? d : m;
    return $clog2(m + 1);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/bit_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level into refclk.
module bit_sync_2ff (
  input  logic refclk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // First stage may go metastable; second stage gives it a full cycle to settle.
  always_ff @(posedge refclk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Supervises one PLL: pulses its reset, waits for filtered lock with bounded retries,
// then releases per-output-clock resets one by one and re-sequences on lock loss.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int NUM_CLOCKS   = 2,
  parameter int RESET_PULSE  = 16,
  parameter int LOCK_TIMEOUT = 1048576,
  parameter int LOCK_FILTER  = 1024,
  parameter int STAGGER      = 64,
  parameter int MAX_RETRY    = 7
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  restart,
  input  logic                  pll_locked,
  output logic                  pll_rst,
  output logic [NUM_CLOCKS-1:0] chan_rst,
  output logic                  ready,
  output logic                  fault,
  output logic [3:0]            retry_count,
  output logic [7:0]            loss_count
);

  localparam int CW = cnt_width(LOCK_TIMEOUT, LOCK_FILTER, RESET_PULSE, STAGGER);
  localparam int IW = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1;

  localparam logic [CW-1:0]         PULSE_LAST   = CW'(RESET_PULSE - 1);
  localparam logic [CW-1:0]         TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0]         FILTER_LAST  = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0]         STAGGER_LAST = CW'(STAGGER - 1);
  localparam logic [IW-1:0]         IDX_LAST     = IW'(NUM_CLOCKS - 1);
  localparam logic [3:0]            RETRY_MAX    = 4'(MAX_RETRY);
  localparam logic [NUM_CLOCKS-1:0] ALL_ONES     = {NUM_CLOCKS{1'b1}};
  localparam logic [NUM_CLOCKS-1:0] BIT0         = NUM_CLOCKS'(1);

  seq_state_t            state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic                  pll_rst_nxt, ready_nxt, fault_nxt;
  logic [NUM_CLOCKS-1:0] chan_rst_nxt;
  logic [3:0]            retry_nxt;
  logic [7:0]            loss_nxt;
  logic                  lk;
  logic                  lost;

  bit_sync_2ff u_lock_sync (
    .refclk (refclk),
    .rst    (rst),
    .d      (pll_locked),
    .q      (lk)
  );

  assign lost = !lk && ((state == S_RELEASE) || (state == S_RUN));

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    idx_nxt      = idx;
    pll_rst_nxt  = pll_rst;
    chan_rst_nxt = chan_rst;
    ready_nxt    = ready;
    fault_nxt    = fault;
    retry_nxt    = retry_count;
    loss_nxt     = loss_count;
    if (restart) begin
      state_nxt    = S_PLLRST;
      cnt_nxt      = '0;
      idx_nxt      = '0;
      pll_rst_nxt  = 1'b1;
      chan_rst_nxt = ALL_ONES;
      ready_nxt    = 1'b0;
      fault_nxt    = 1'b0;
      retry_nxt    = 4'd0;
    end else if (lost) begin
      state_nxt    = S_PLLRST;
      cnt_nxt      = '0;
      idx_nxt      = '0;
      pll_rst_nxt  = 1'b1;
      chan_rst_nxt = ALL_ONES;
      ready_nxt    = 1'b0;
      loss_nxt     = sat_inc8(loss_count);
    end else begin
      case (state)
        S_PLLRST: begin
          if (cnt == PULSE_LAST) begin
            state_nxt   = S_WAITLOCK;
            cnt_nxt     = '0;
            pll_rst_nxt = 1'b0;
          end else begin
            cnt_nxt     = cnt + CW'(1);
            pll_rst_nxt = 1'b1;
          end
        end
        S_WAITLOCK: begin
          if (lk) begin
            state_nxt = S_FILTER;
            cnt_nxt   = '0;
          end else if (cnt != TIMEOUT_LAST) begin
            cnt_nxt = cnt + CW'(1);
          end else if (retry_count < RETRY_MAX) begin
            retry_nxt   = retry_count + 4'd1;
            state_nxt   = S_PLLRST;
            cnt_nxt     = '0;
            pll_rst_nxt = 1'b1;
          end else begin
            state_nxt = S_FAULT;
            fault_nxt = 1'b1;
          end
        end
        S_FILTER: begin
          // A single dropout sends us back to waiting without spending a retry.
          if (!lk) begin
            state_nxt = S_WAITLOCK;
            cnt_nxt   = '0;
          end else if (cnt == FILTER_LAST) begin
            state_nxt = S_RELEASE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        S_RELEASE: begin
          if (cnt != STAGGER_LAST) begin
            cnt_nxt = cnt + CW'(1);
          end else begin
            chan_rst_nxt = chan_rst & ~(BIT0 << idx);
            cnt_nxt      = '0;
            if (idx == IDX_LAST) begin
              state_nxt = S_RUN;
              retry_nxt = 4'd0;
            end else begin
              idx_nxt = idx + IW'(1);
            end
          end
        end
        S_RUN: begin
          ready_nxt = 1'b1;
        end
        S_FAULT: begin
          pll_rst_nxt  = 1'b0;
          chan_rst_nxt = ALL_ONES;
          ready_nxt    = 1'b0;
          fault_nxt    = 1'b1;
        end
        default: begin
          state_nxt    = S_PLLRST;
          cnt_nxt      = '0;
          idx_nxt      = '0;
          pll_rst_nxt  = 1'b1;
          chan_rst_nxt = ALL_ONES;
          ready_nxt    = 1'b0;
          fault_nxt    = 1'b0;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state       <= S_PLLRST;
      cnt         <= '0;
      idx         <= '0;
      pll_rst     <= 1'b1;
      chan_rst    <= ALL_ONES;
      ready       <= 1'b0;
      fault       <= 1'b0;
      retry_count <= 4'd0;
      loss_count  <= 8'd0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      pll_rst     <= pll_rst_nxt;
      chan_rst    <= chan_rst_nxt;
      ready       <= ready_nxt;
      fault       <= fault_nxt;
      retry_count <= retry_nxt;
      loss_count  <= loss_nxt;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: directed scenarios plus random lock
// behaviour, all compared against a phase/elapsed-time reference model.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

  localparam int NC = 3;
  localparam int RP = 4;
  localparam int LT = 32;
  localparam int LF = 8;
  localparam int ST = 2;
  localparam int MR = 2;

  localparam int PH_PULSE = 0;
  localparam int PH_WAIT  = 1;
  localparam int PH_FILT  = 2;
  localparam int PH_REL   = 3;
  localparam int PH_RUN   = 4;
  localparam int PH_FAULT = 5;

  localparam logic [NC-1:0] ONES = {NC{1'b1}};

  logic          refclk = 1'b0;
  logic          rst = 1'b1;
  logic          restart = 1'b0;
  logic          pll_locked = 1'b0;
  logic          pll_rst;
  logic [NC-1:0] chan_rst;
  logic          ready;
  logic          fault;
  logic [3:0]    retry_count;
  logic [7:0]    loss_count;
  logic [NC+14:0] dut_out;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: current phase, cycles elapsed in it, counters, lock delay line.
  int   ph = PH_PULSE;
  int   t = 0;
  int   m_retry = 0;
  int   m_loss = 0;
  logic m_p1 = 1'b0;
  logic m_p2 = 1'b0;

  pll_reset_sequencer #(
    .NUM_CLOCKS   (NC),
    .RESET_PULSE  (RP),
    .LOCK_TIMEOUT (LT),
    .LOCK_FILTER  (LF),
    .STAGGER      (ST),
    .MAX_RETRY    (MR)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .restart     (restart),
    .pll_locked  (pll_locked),
    .pll_rst     (pll_rst),
    .chan_rst    (chan_rst),
    .ready       (ready),
    .fault       (fault),
    .retry_count (retry_count),
    .loss_count  (loss_count)
  );

  assign dut_out = {pll_rst, chan_rst, ready, fault, retry_count, loss_count};

  always #5 refclk = ~refclk;

  // Outputs follow from phase and elapsed time: in release, one bit per STAGGER cycles.
  function automatic logic [NC+14:0] model_out();
    logic [NC-1:0] ch;
    if (ph == PH_REL) ch = ONES << (t / ST);
    else if (ph == PH_RUN) ch = '0;
    else ch = ONES;
    return {(ph == PH_PULSE), ch, (ph == PH_RUN && t >= 1), (ph == PH_FAULT),
            4'(m_retry), 8'(m_loss)};
  endfunction

  task automatic model_step(input logic r, input logic rs, input logic lin);
    logic lk;
    lk = m_p2;
    if (r) begin
      ph = PH_PULSE; t = 0; m_retry = 0; m_loss = 0; m_p1 = 1'b0; m_p2 = 1'b0;
    end else begin
      m_p2 = m_p1;
      m_p1 = lin;
      if (rs) begin
        ph = PH_PULSE; t = 0; m_retry = 0;
      end else begin
        case (ph)
          PH_PULSE: if (t == RP - 1) begin ph = PH_WAIT; t = 0; end else t++;
          PH_WAIT: begin
            if (lk) begin ph = PH_FILT; t = 0; end
            else if (t < LT - 1) t++;
            else if (m_retry < MR) begin m_retry++; ph = PH_PULSE; t = 0; end
            else ph = PH_FAULT;
          end
          PH_FILT: begin
            if (!lk) begin ph = PH_WAIT; t = 0; end
            else if (t == LF - 1) begin ph = PH_REL; t = 0; end
            else t++;
          end
          PH_REL, PH_RUN: begin
            if (!lk) begin
              m_loss = (m_loss < 255) ? m_loss + 1 : 255; ph = PH_PULSE; t = 0;
            end else if (ph == PH_REL && t == NC * ST - 1) begin
              ph = PH_RUN; t = 0; m_retry = 0;
            end else if (t < 100000) t++;
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic tick(input logic r, input logic rs, input logic lin);
    rst = r;
    restart = rs;
    pll_locked = lin;
    @(posedge refclk);
    model_step(r, rs, lin);
    @(negedge refclk);
  endtask

  task automatic test_reset();
    repeat (3) tick(1'b1, 1'b0, 1'b0);
    n_assert++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL reset_pll_rst: got %b want 1", pll_rst); end
    n_assert++; if (chan_rst !== ONES) begin n_fail++; $display("FAIL reset_chan_rst: got %b want %b", chan_rst, ONES); end
    n_assert++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_assert++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", fault); end
    n_assert++; if (retry_count !== 4'd0) begin n_fail++; $display("FAIL reset_retry: got %0d want 0", retry_count); end
    n_assert++; if (loss_count !== 8'd0) begin n_fail++; $display("FAIL reset_loss: got %0d want 0", loss_count); end
  endtask

  task automatic test_nominal();
    int pulse;
    int chg_t[$];
    logic [NC-1:0] chg_v[$];
    logic [NC-1:0] prev;
    int trdy;
    repeat (3) tick(1'b1, 1'b0, 1'b0);
    pulse = int'(pll_rst);
    prev = chan_rst;
    trdy = -1;
    for (int c = 0; c < 80; c++) begin
      tick(1'b0, 1'b0, c >= 10);
      n_assert++;
      if (dut_out !== model_out()) begin n_fail++; $display("FAIL nominal_model cyc %0d: got %h want %h", c, dut_out, model_out()); end
      if (pll_rst) pulse++;
      if (chan_rst !== prev) begin chg_t.push_back(c); chg_v.push_back(chan_rst); prev = chan_rst; end
      if (ready && trdy < 0) trdy = c;
    end
    n_assert++; if (pulse != RP) begin n_fail++; $display("FAIL nominal_pulse_len: got %0d want %0d", pulse, RP); end
    n_assert++;
    if (chg_v.size() != NC) begin
      n_fail++; $display("FAIL nominal_release_count: got %0d want %0d", chg_v.size(), NC);
    end else begin
      n_assert++; if (chg_t[0] != 10 + 2 + LF + ST) begin n_fail++; $display("FAIL nominal_first_release: got %0d want %0d", chg_t[0], 10 + 2 + LF + ST); end
      for (int k = 0; k < NC; k++) begin
        n_assert++;
        if (chg_v[k] !== (ONES << (k + 1))) begin n_fail++; $display("FAIL nominal_release_order %0d: got %b want %b", k, chg_v[k], ONES << (k + 1)); end
        if (k > 0) begin
          n_assert++;
          if (chg_t[k] - chg_t[k-1] != ST) begin n_fail++; $display("FAIL nominal_stagger %0d: got %0d want %0d", k, chg_t[k] - chg_t[k-1], ST); end
        end
      end
      n_assert++; if (trdy != chg_t[NC-1] + 1) begin n_fail++; $display("FAIL nominal_ready_time: got %0d want %0d", trdy, chg_t[NC-1] + 1); end
    end
    n_assert++; if (retry_count !== 4'd0) begin n_fail++; $display("FAIL nominal_retry: got %0d want 0", retry_count); end
  endtask

  task automatic test_timeout_fault();
    int plen[$];
    int gaps[$];
    int rstart[$];
    int len;
    int gap;
    logic prev;
    repeat (3) tick(1'b1, 1'b0, 1'b0);
    len = 1; gap = 0; prev = 1'b1;
    rstart.push_back(int'(retry_count));
    for (int c = 0; c < 130; c++) begin
      tick(1'b0, 1'b0, 1'b0);
      n_assert++;
      if (dut_out !== model_out()) begin n_fail++; $display("FAIL timeout_model cyc %0d: got %h want %h", c, dut_out, model_out()); end
      if (pll_rst && !prev) begin gaps.push_back(gap); len = 1; rstart.push_back(int'(retry_count)); end
      else if (pll_rst) len++;
      else if (prev) begin plen.push_back(len); gap = 1; end
      else gap++;
      prev = pll_rst;
    end
    n_assert++;
    if (plen.size() != MR + 1 || gaps.size() != MR || rstart.size() != MR + 1) begin
      n_fail++; $display("FAIL timeout_pulse_count: got %0d pulses want %0d", plen.size(), MR + 1);
    end else begin
      for (int k = 0; k <= MR; k++) begin
        n_assert++; if (plen[k] != RP) begin n_fail++; $display("FAIL timeout_pulse_len %0d: got %0d want %0d", k, plen[k], RP); end
        n_assert++; if (rstart[k] != k) begin n_fail++; $display("FAIL timeout_retry_step %0d: got %0d want %0d", k, rstart[k], k); end
        if (k < MR) begin
          n_assert++; if (gaps[k] != LT) begin n_fail++; $display("FAIL timeout_wait_len %0d: got %0d want %0d", k, gaps[k], LT); end
        end
      end
    end
    n_assert++; if (fault !== 1'b1) begin n_fail++; $display("FAIL timeout_fault: got %b want 1", fault); end
    n_assert++; if (pll_rst !== 1'b0) begin n_fail++; $display("FAIL timeout_fault_pll_rst: got %b want 0", pll_rst); end
    n_assert++; if (chan_rst !== ONES) begin n_fail++; $display("FAIL timeout_fault_chan: got %b want %b", chan_rst, ONES); end
    n_assert++; if (ready !== 1'b0) begin n_fail++; $display("FAIL timeout_fault_ready: got %b want 0", ready); end
  endtask

  task automatic test_glitch();
    int first;
    logic lv;
    repeat (3) tick(1'b1, 1'b0, 1'b0);
    first = -1;
    for (int c = 0; c < 60; c++) begin
      lv = (c >= 8 && c <= 12) || (c >= 14);
      tick(1'b0, 1'b0, lv);
      n_assert++;
      if (dut_out !== model_out()) begin n_fail++; $display("FAIL glitch_model cyc %0d: got %h want %h", c, dut_out, model_out()); end
      n_assert++;
      if (retry_count !== 4'd0) begin n_fail++; $display("FAIL glitch_retry cyc %0d: got %0d want 0", c, retry_count); end
      if (chan_rst !== ONES && first < 0) first = c;
    end
    n_assert++;
    if (first < 14 + 2 + LF) begin n_fail++; $display("FAIL glitch_early_release: got cycle %0d want >= %0d", first, 14 + 2 + LF); end
  endtask

  task automatic test_loss_run();
    repeat (3) tick(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 100 && ready !== 1'b1; c++) tick(1'b0, 1'b0, c >= 5);
    n_assert++; if (ready !== 1'b1) begin n_fail++; $display("FAIL loss_run_ready_timeout: got %b want 1", ready); end
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0, 1'b0);
      n_assert++;
      if (dut_out !== model_out()) begin n_fail++; $display("FAIL loss_run_model %0d: got %h want %h", k, dut_out, model_out()); end
    end
    n_assert++; if (chan_rst !== ONES) begin n_fail++; $display("FAIL loss_run_chan: got %b want %b", chan_rst, ONES); end
    n_assert++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL loss_run_pll_rst: got %b want 1", pll_rst); end
    n_assert++; if (ready !== 1'b0) begin n_fail++; $display("FAIL loss_run_ready: got %b want 0", ready); end
    n_assert++; if (loss_count !== 8'd1) begin n_fail++; $display("FAIL loss_run_count: got %0d want 1", loss_count); end
    for (int c = 0; c < 100 && ready !== 1'b1; c++) begin
      tick(1'b0, 1'b0, 1'b1);
      n_assert++;
      if (dut_out !== model_out()) begin n_fail++; $display("FAIL loss_run_rerun cyc %0d: got %h want %h", c, dut_out, model_out()); end
    end
    n_assert++; if (ready !== 1'b1) begin n_fail++; $display("FAIL loss_run_rerun_timeout: got %b want 1", ready); end
  endtask

  task automatic test_loss_release();
    repeat (3) tick(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 100 && chan_rst !== (ONES << 1); c++) tick(1'b0, 1'b0, c >= 5);
    n_assert++; if (chan_rst !== (ONES << 1)) begin n_fail++; $display("FAIL loss_rel_reach: got %b want %b", chan_rst, ONES << 1); end
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0, 1'b0);
      n_assert++;
      if (dut_out !== model_out()) begin n_fail++; $display("FAIL loss_rel_model %0d: got %h want %h", k, dut_out, model_out()); end
      n_assert++;
      if (chan_rst === '0) begin n_fail++; $display("FAIL loss_rel_full_release %0d: got %b want nonzero", k, chan_rst); end
    end
    n_assert++; if (chan_rst !== ONES) begin n_fail++; $display("FAIL loss_rel_chan: got %b want %b", chan_rst, ONES); end
    n_assert++; if (loss_count !== 8'd1) begin n_fail++; $display("FAIL loss_rel_count: got %0d want 1", loss_count); end
  endtask

  task automatic test_restart();
    int pulse;
    repeat (3) tick(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 100 && ready !== 1'b1; c++) tick(1'b0, 1'b0, c >= 5);
    for (int c = 0; c < 130; c++) tick(1'b0, 1'b0, 1'b0);
    n_assert++; if (fault !== 1'b1) begin n_fail++; $display("FAIL restart_reach_fault: got %b want 1", fault); end
    tick(1'b0, 1'b1, 1'b0);
    n_assert++; if (fault !== 1'b0) begin n_fail++; $display("FAIL restart_fault: got %b want 0", fault); end
    n_assert++; if (retry_count !== 4'd0) begin n_fail++; $display("FAIL restart_retry: got %0d want 0", retry_count); end
    n_assert++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL restart_pll_rst: got %b want 1", pll_rst); end
    n_assert++; if (chan_rst !== ONES) begin n_fail++; $display("FAIL restart_chan: got %b want %b", chan_rst, ONES); end
    n_assert++; if (loss_count !== 8'd1) begin n_fail++; $display("FAIL restart_keeps_loss: got %0d want 1", loss_count); end
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    pulse = int'(pll_rst);
    for (int c = 0; c < 20 && pll_rst === 1'b1; c++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (pll_rst) pulse++;
    end
    n_assert++; if (pulse != RP) begin n_fail++; $display("FAIL restart_in_pulse_len: got %0d want %0d", pulse, RP); end
  endtask

  task automatic test_rst_priority();
    for (int c = 0; c < 45; c++) tick(1'b0, 1'b0, 1'b0);
    n_assert++; if (retry_count !== 4'd1) begin n_fail++; $display("FAIL prio_setup_retry: got %0d want 1", retry_count); end
    tick(1'b1, 1'b1, 1'b0);
    n_assert++; if (loss_count !== 8'd0) begin n_fail++; $display("FAIL prio_loss: got %0d want 0", loss_count); end
    n_assert++; if (retry_count !== 4'd0) begin n_fail++; $display("FAIL prio_retry: got %0d want 0", retry_count); end
    n_assert++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL prio_pll_rst: got %b want 1", pll_rst); end
    n_assert++; if (chan_rst !== ONES || ready !== 1'b0 || fault !== 1'b0) begin
      n_fail++; $display("FAIL prio_outputs: got chan %b ready %b fault %b want %b 0 0", chan_rst, ready, fault, ONES);
    end
  endtask

  task automatic test_random();
    int seg;
    logic lv;
    logic r;
    logic rs;
    seg = 0;
    lv = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (seg == 0) begin
        lv = ($urandom_range(0, 9) < 7);
        seg = lv ? int'($urandom_range(5, 80)) : int'($urandom_range(1, 40));
      end
      seg--;
      r  = ($urandom_range(0, 599) == 0);
      rs = ($urandom_range(0, 149) == 0);
      tick(r, rs, lv);
      n_assert++;
      if (dut_out !== model_out()) begin n_fail++; $display("FAIL random_model cyc %0d: got %h want %h", c, dut_out, model_out()); end
      n_assert++;
      if ((ready && (chan_rst !== '0 || fault)) || (fault && chan_rst !== ONES)) begin
        n_fail++; $display("FAIL random_invariant cyc %0d: got ready %b fault %b chan %b", c, ready, fault, chan_rst);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout_fault();
    test_glitch();
    test_loss_run();
    test_loss_release();
    test_restart();
    test_rst_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
